// File: rtl/serial_subtractor_pkg.sv
// Shared constants for the bit-serial subtractor slice.
// Default operand width used by the top when not overridden.
package serial_subtractor_pkg;

  localparam int SS_DEF_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_fs.sv
// One-bit full subtractor cell, purely combinational.
// Same port shape as full_adder so the two paths read alike.
module full_subtractor (
  input  logic in1,
  input  logic in2,
  input  logic bin,
  output logic diff,
  output logic bout
);

  logic w_x;

  assign w_x  = in1 ^ in2;
  assign diff = w_x ^ bin;
  assign bout = (~in1 & in2) | (~w_x & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = minuend - subtrahend - bin, LSB first.
// One bit per clock through a single full_subtractor cell.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = SS_DEF_WIDTH
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] minuend,
  input  logic [WIDTH-1:0] subtrahend,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_d_sr;
  logic [WIDTH-1:0] r_diff;
  logic [CNT_W-1:0] r_cnt;
  logic             r_br;
  logic             r_bout;
  logic             r_busy;
  logic             r_done;

  logic             w_d;
  logic             w_br_nxt;
  logic             w_last;
  logic [WIDTH-1:0] w_d_nxt;

  full_subtractor u_fs (
    .in1  (r_a_sr[0]),
    .in2  (r_b_sr[0]),
    .bin  (r_br),
    .diff (w_d),
    .bout (w_br_nxt)
  );

  assign w_d_nxt = {w_d, r_d_sr[WIDTH-1:1]};
  assign w_last  = (r_cnt == CNT_W'(WIDTH - 1));

  // busy/done are registered alongside the state so start never
  // reaches them combinationally.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= S_IDLE;
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_d_sr  <= '0;
      r_diff  <= '0;
      r_cnt   <= '0;
      r_br    <= 1'b0;
      r_bout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a_sr  <= minuend;
            r_b_sr  <= subtrahend;
            r_br    <= bin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_br   <= w_br_nxt;
          r_d_sr <= w_d_nxt;
          r_a_sr <= {1'b0, r_a_sr[WIDTH-1:1]};
          r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
          r_cnt  <= r_cnt + 1'b1;
          if (w_last) begin
            r_diff  <= w_d_nxt;
            r_bout  <= w_br_nxt;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign diff = r_diff;
  assign bout = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed + random bench for serial_subtractor.
// Expected results queue on drive, pop on done.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         bin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  serial_subtractor #(.WIDTH(W)) dut (
    .sys_clk    (clk),
    .sys_rst_n  (rst_n),
    .start      (start),
    .minuend    (a),
    .subtrahend (b),
    .bin        (bin),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .bout       (bout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int lat_ref = 0;
  int prev_done = -1;
  bit b2b = 1'b0;
  logic [W:0] q[$];

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] x,
                                       input logic [W-1:0] y,
                                       input logic bi);
    return {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
  endfunction

  task automatic set_ops(input logic [W-1:0] x,
                         input logic [W-1:0] y,
                         input logic bi);
    a = x;
    b = y;
    bin = bi;
    start = 1'b1;
    q.push_back(model(x, y, bi));
    lat_ref = cyc;
  endtask

  task automatic handle_done();
    logic [W:0] e;
    done_cnt++;
    check("sb_nonempty", 32'(q.size() != 0), 1);
    if (q.size() != 0) begin
      e = q.pop_front();
      check("diff", diff, e[W-1:0]);
      check("bout", bout, e[W]);
    end
    if (!b2b) check("latency", cyc - lat_ref, W + 1);
    if (b2b && prev_done >= 0) check("spacing", cyc - prev_done, W + 2);
    prev_done = cyc;
  endtask

  task automatic wait_done(input int bound, input bit chk_busy);
    bit got;
    got = 1'b0;
    for (int i = 0; i < bound && !got; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        handle_done();
      end else if (chk_busy) begin
        check("busy_cont", busy, 1);
      end
    end
    check("done_seen", got, 1);
  endtask

  task automatic op(input logic [W-1:0] x,
                    input logic [W-1:0] y,
                    input logic bi);
    logic [W:0] e;
    e = model(x, y, bi);
    @(negedge clk);
    set_ops(x, y, bi);
    @(posedge clk);
    #1 start = 1'b0;
    check("busy_run", busy, 1);
    wait_done(W + 4, 1'b0);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("busy_idle", busy, 0);
    repeat (2) @(negedge clk);
    check("diff_hold", diff, e[W-1:0]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    int extra;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    op(8'h35, 8'h12, 1'b0);
    op(8'h12, 8'h35, 1'b0);
    op(8'h00, 8'h00, 1'b1);
    op(8'hFF, 8'hFF, 1'b0);

    // start pulse mid-run must be dropped
    @(negedge clk);
    set_ops(8'h5A, 8'h3C, 1'b0);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    a = 8'hFF;
    b = 8'h01;
    bin = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(W + 4, 1'b1);
    extra = 0;
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("t4_single_done", extra, 0);
    check("t4_q_empty", q.size(), 0);
    check("t4_diff_kept", diff, 8'h1E);

    // reset mid-run aborts without a done pulse
    @(negedge clk);
    set_ops(8'hC3, 8'h11, 1'b0);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_busy", busy, 0);
    check("t5_diff", diff, 0);
    check("t5_bout", bout, 0);
    check("t5_done", done, 0);
    q.delete();
    dc = done_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("t5_no_done", extra, 0);
    check("t5_cnt", done_cnt, dc);
    op(8'h80, 8'h01, 1'b0);

    // back-to-back with start held high
    b2b = 1'b1;
    prev_done = -1;
    @(negedge clk);
    set_ops(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)));
    for (int k = 0; k < 1000; k++) begin
      wait_done(2 * W + 4, 1'b0);
      if (k < 999)
        set_ops(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
                1'($urandom_range(0, 1)));
      else
        start = 1'b0;
    end
    b2b = 1'b0;
    repeat (W + 4) @(negedge clk);
    check("t6_q_empty", q.size(), 0);
    check("t6_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
